// File: rtl/rk_core_pkg.sv
// rk_core_pkg: shared opcode/state types, instruction field layout and
// one-hot stage encodings for the RK core.
package rk_core_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LI   = 4'h8,
    OP_BEQZ = 4'h9,
    OP_JAL  = 4'hA,
    OP_HALT = 4'hB,
    OP_RETI = 4'hC
  } opcode_e;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  localparam int IMM_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int RS1_LSB = 8;
  localparam int RD_LSB  = 4;
  localparam int OP_LSB  = 0;

  localparam logic [3:0] STAGE_NONE   = 4'b0000;
  localparam logic [3:0] STAGE_FETCH  = 4'b0001;
  localparam logic [3:0] STAGE_DECODE = 4'b0010;
  localparam logic [3:0] STAGE_EXEC   = 4'b0100;
  localparam logic [3:0] STAGE_WB     = 4'b1000;

endpackage

// File: rtl/rk_regfile.sv
// rk_regfile: NREG x XLEN register file, two asynchronous read ports,
// one synchronous write port, r0 hardwired to zero.
module rk_regfile #(
  parameter int XLEN = 16,
  parameter int NREG = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREG)-1:0]  rs1_addr,
  input  logic [$clog2(NREG)-1:0]  rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [XLEN-1:0]          wdata
);

  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array sits in flops (not RAM), so it can and must be cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rk_core.sv
// rk_core: multi-cycle RK processor (BOOT/FETCH/DECODE/EXEC/WB/HALT).
// Optional interrupt support is enabled by defining RK_CORE_INTR_EN.
module rk_core
  import rk_core_pkg::*;
#(
  parameter int              XLEN     = 16,
  parameter int              NREG     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] INTR_VEC = XLEN'('h8)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic            intr,
  output logic            halted,
  output logic [3:0]      stage,
  output logic            wb_en,
  output logic [3:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  localparam int RW  = $clog2(NREG);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic            boot_q, halt_q, take_irq;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, a_q, b_q, npc_q;
  logic            wb_en_q;
  logic [3:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc_inc, exec_res, exec_npc;
  logic            exec_wr;
  logic [3:0]      op;
  logic [RW-1:0]   rd;

  assign op     = ir_q[OP_LSB +: 4];
  assign rd     = ir_q[RD_LSB +: RW];
  assign imm    = XLEN'($signed(ir_q[IMM_LSB +: 16]));
  assign pc_inc = pc_q + XLEN'(1);

`ifdef RK_CORE_INTR_EN
  logic            ie_q, reti_q;
  logic [XLEN-1:0] epc_q;
  // RETI's own WB never takes an interrupt, so a held request waits one instruction.
  assign take_irq = intr && ie_q && ((state_q == ST_WB && !reti_q) || state_q == ST_HALT);
`else
  logic [XLEN:0] unused_cfg;
  assign take_irq   = 1'b0;
  assign unused_cfg = {intr, INTR_VEC};
`endif

  rk_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (ir_q[RS1_LSB +: RW]),
    .rs2_addr (ir_q[RS2_LSB +: RW]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_en_q),
    .waddr    (wb_addr_q[RW-1:0]),
    .wdata    (wb_data_q)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // NOTE: defaults first, so no path through this block leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   if (boot_q) state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = (halt_q && !take_irq) ? ST_HALT : ST_FETCH;
      ST_HALT:   if (take_irq) state_d = ST_FETCH;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    exec_res = '0;
    exec_npc = pc_inc;
    exec_wr  = 1'b1;
    case (op)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLL:  exec_res = a_q << b_q[SHW-1:0];
      OP_SRL:  exec_res = a_q >> b_q[SHW-1:0];
      OP_ADDI: exec_res = a_q + imm;
      OP_LI:   exec_res = imm;
      OP_BEQZ: begin
        exec_wr = 1'b0;
        if (a_q == '0) exec_npc = imm;
      end
      OP_JAL: begin
        exec_res = pc_inc;
        exec_npc = a_q + imm;
      end
      default: exec_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q    <= 1'b0;
      halt_q    <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      npc_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`ifdef RK_CORE_INTR_EN
      ie_q      <= 1'b1;
      reti_q    <= 1'b0;
      epc_q     <= '0;
`endif
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        ST_BOOT:   boot_q <= 1'b1;
        ST_FETCH:  if (imem_ack) ir_q <= imem_data;
        ST_DECODE: begin
          a_q <= rs1_data;
          b_q <= rs2_data;
        end
        ST_EXEC: begin
          npc_q   <= exec_npc;
          halt_q  <= (op == OP_HALT);
          wb_en_q <= exec_wr && (rd != '0);
          if (exec_wr && rd != '0) begin
            wb_addr_q <= 4'(rd);
            wb_data_q <= exec_res;
          end
`ifdef RK_CORE_INTR_EN
          reti_q <= (op == OP_RETI);
`endif
        end
        ST_WB: begin
`ifdef RK_CORE_INTR_EN
          if (reti_q) begin
            pc_q <= epc_q;
            ie_q <= 1'b1;
          end else if (take_irq) begin
            epc_q <= npc_q;
            pc_q  <= INTR_VEC;
            ie_q  <= 1'b0;
          end else begin
            pc_q <= npc_q;
          end
`else
          pc_q <= npc_q;
`endif
        end
`ifdef RK_CORE_INTR_EN
        ST_HALT: if (take_irq) begin
          epc_q <= pc_q;
          pc_q  <= INTR_VEC;
          ie_q  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = imem_req ? pc_q : '0;
  assign halted    = (state_q == ST_HALT);
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;

  always_comb begin
    stage = STAGE_NONE;
    case (state_q)
      ST_FETCH:  stage = STAGE_FETCH;
      ST_DECODE: stage = STAGE_DECODE;
      ST_EXEC:   stage = STAGE_EXEC;
      ST_WB:     stage = STAGE_WB;
      default:   stage = STAGE_NONE;
    endcase
  end

endmodule

// File: tb/tb_rk_core.sv
// tb_rk_core: table-driven program plus hand sequences for wait states,
// mid-fetch reset and halt; fetches and write-backs go through scoreboards.
module tb_rk_core;
  import rk_core_pkg::*;

  localparam int XLEN = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] INTR_VEC = 16'h0008;

  logic        clk, rst_n, imem_req, imem_ack, intr, halted, wb_en;
  logic [15:0] imem_addr, wb_data;
  logic [31:0] imem_data;
  logic [3:0]  stage, wb_addr;

  rk_core #(.XLEN(XLEN), .NREG(16), .RESET_PC(RESET_PC), .INTR_VEC(INTR_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .intr(intr), .halted(halted),
    .stage(stage), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct { int pc; logic [31:0] instr; bit wr; int rd; int data; } vec_t;
  typedef struct { int addr; int data; } wb_t;

  int          checks = 0, errors = 0, cyc = 0;
  int          wait_left = 0, max_wait = 0, t0, stable_bad;
  bit          mem_on = 0;
  logic [31:0] mem [256];
  int          fetch_q [$];
  wb_t         wb_q [$];
  vec_t        prog [19];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {imm[15:0], rs2[3:0], rs1[3:0], rd[3:0], op[3:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; intr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 500) begin @(negedge clk); #1; n++; end
    check(name, halted, 1);
  endtask

  task automatic wait_fetch(input logic [15:0] a);
    int n = 0;
    do begin @(negedge clk); #2; n++; end
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 300);
    check("fetch_reached", {imem_req, imem_addr}, {1'b1, a});
  endtask

  task automatic halt_hold(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (halted !== 1'b1 || imem_req !== 1'b0 || stage !== STAGE_NONE) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic drained(input string name);
    check({name, "_fetch_left"}, fetch_q.size(), 0);
    check({name, "_wb_left"}, wb_q.size(), 0);
  endtask

  // Memory responder: acks after a random number of wait cycles.
  initial forever begin
    @(negedge clk);
    if (mem_on) begin
      if (imem_req === 1'b1) begin
        if (wait_left == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr[7:0]];
        end else begin
          imem_ack = 1'b0;
          wait_left--;
        end
      end else begin
        imem_ack  = 1'b0;
        wait_left = $urandom_range(0, max_wait);
      end
    end
  end

  // Scoreboard monitor for fetch addresses and register writes.
  initial forever begin
    @(negedge clk); #1;
    if (rst_n === 1'b1) begin
      if (imem_req === 1'b1 && imem_ack === 1'b1) begin
        if (fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected actual=%0h expected=none", imem_addr);
        end else check("fetch_addr", imem_addr, fetch_q.pop_front());
      end
      if (wb_en === 1'b1) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected actual=r%0d:%0h expected=none", wb_addr, wb_data);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          check("wb_addr", wb_addr, e.addr);
          check("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    prog[0]  = '{'h00, enc(OP_ADDI, 1, 0, 0, 5),        1, 1,  'h0005};
    prog[1]  = '{'h01, enc(OP_ADDI, 2, 0, 0, 7),        1, 2,  'h0007};
    prog[2]  = '{'h02, enc(OP_ADD,  3, 1, 2, 0),        1, 3,  'h000C};
    prog[3]  = '{'h03, enc(OP_JAL,  5, 0, 0, 'h10),     1, 5,  'h0004};
    prog[4]  = '{'h10, enc(OP_ADDI, 0, 0, 0, 9),        0, 0,  0};
    prog[5]  = '{'h11, enc(OP_SUB,  4, 0, 1, 0),        1, 4,  'hFFFB};
    prog[6]  = '{'h12, enc(OP_ADDI, 6, 0, 0, 15),       1, 6,  'h000F};
    prog[7]  = '{'h13, enc(OP_ADDI, 7, 0, 0, 1),        1, 7,  'h0001};
    prog[8]  = '{'h14, enc(OP_SLL,  8, 7, 6, 0),        1, 8,  'h8000};
    prog[9]  = '{'h15, enc(OP_SRL,  9, 8, 6, 0),        1, 9,  'h0001};
    prog[10] = '{'h16, enc(OP_BEQZ, 0, 1, 0, 'h30),     0, 0,  0};
    prog[11] = '{'h17, enc(OP_BEQZ, 0, 0, 0, 'h20),     0, 0,  0};
    prog[12] = '{'h20, enc(OP_AND, 10, 3, 2, 0),        1, 10, 'h0004};
    prog[13] = '{'h21, enc(OP_OR,  11, 3, 2, 0),        1, 11, 'h000F};
    prog[14] = '{'h22, enc(OP_XOR, 12, 3, 2, 0),        1, 12, 'h000B};
    prog[15] = '{'h23, enc(OP_LI,  13, 0, 0, 'h8001),   1, 13, 'h8001};
    prog[16] = '{'h24, enc(OP_ADDI, 14, 1, 0, 'hFFFA),  1, 14, 'hFFFF};
    prog[17] = '{'h25, enc('hD, 15, 1, 2, 0),           0, 0,  0};
    prog[18] = '{'h26, enc(OP_HALT, 0, 0, 0, 0),        0, 0,  0};

    for (int i = 0; i < 256; i++) mem[i] = enc('hF, 0, 0, 0, 0);
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; intr = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {imem_req, halted, stage, wb_en, wb_addr, wb_data, imem_addr}, '0);

    // Main program with random fetch wait states.
    for (int i = 0; i < $size(prog); i++) begin
      mem[prog[i].pc[7:0]] = prog[i].instr;
      fetch_q.push_back(prog[i].pc);
      if (prog[i].wr) wb_q.push_back('{prog[i].rd, prog[i].data});
    end
    max_wait = 2;
    mem_on   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt("main_halted");
    halt_hold("halt_hold_20", 20);
    drained("main");

    // Mid-fetch reset with a pending ack, then a 3-wait-state fetch.
    mem_on = 1'b0;
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b1; imem_data = enc(OP_ADDI, 1, 0, 0, 'h55);
    #1 check("reset_mid_outputs", {imem_req, halted, stage, wb_en, wb_addr, wb_data, imem_addr}, '0);
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; rst_n = 1'b1;
    fetch_q.push_back(RESET_PC);
    wb_q.push_back('{2, 0});
    @(posedge clk); #1 check("boot_no_req", imem_req, 0);
    @(posedge clk); #1 check("first_req", {imem_req, imem_addr}, {1'b1, RESET_PC});
    t0 = cyc;
    stable_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) stable_bad++;
      imem_ack  = (i == 3);
      imem_data = enc(OP_ADD, 2, 1, 0, 0);
    end
    check("fetch_hold_stable", stable_bad, 0);
    @(posedge clk); #1 imem_ack = 1'b0;
    @(posedge clk); #1 check("stage_exec", stage, STAGE_EXEC);
    imem_ack = 1'b1; imem_data = enc(OP_ADDI, 3, 0, 0, 'h77);
    @(posedge clk); #1 imem_ack = 1'b0;
    check("stray_ack_ignored", stage, STAGE_WB);
    @(posedge clk); #1 check("cycles_3_waits", cyc - t0, 7);
    check("next_fetch_addr", imem_addr, 1);
    mem[1] = enc(OP_HALT, 0, 0, 0, 0);
    fetch_q.push_back(1);
    wait_left = 0; max_wait = 0; mem_on = 1'b1;
    wait_halt("seq_halted");
    drained("seq");

`ifdef RK_CORE_INTR_EN
    mem[0] = enc(OP_ADDI, 1, 0, 0, 1);
    mem[1] = enc(OP_ADDI, 2, 0, 0, 2);
    mem[2] = enc(OP_ADDI, 3, 0, 0, 3);
    mem[3] = enc(OP_HALT, 0, 0, 0, 0);
    mem[4] = enc(OP_HALT, 0, 0, 0, 0);
    mem[8] = enc(OP_ADDI, 4, 0, 0, 4);
    mem[9] = enc(OP_RETI, 0, 0, 0, 0);
    foreach (mem[i]) if (i == 0) begin end
    fetch_q = '{0, 1, 2, 8, 9, 3};
    wb_q    = '{'{1, 1}, '{2, 2}, '{3, 3}, '{4, 4}};
    max_wait = 1;
    do_reset();
    wait_fetch(16'd2);
    intr = 1'b1;
    wait_fetch(16'd3);
    intr = 1'b0;
    wait_halt("intr_halted");
    drained("intr");
    fetch_q = '{8, 9, 4};
    wb_q    = '{'{4, 4}};
    intr = 1'b1;
    wait_fetch(INTR_VEC);
    intr = 1'b0;
    wait_halt("wake_halted");
    drained("wake");
`else
    mem[0] = enc(OP_ADDI, 1, 0, 0, 1);
    mem[1] = enc(OP_ADDI, 2, 0, 0, 2);
    mem[2] = enc(OP_HALT, 0, 0, 0, 0);
    fetch_q = '{0, 1, 2};
    wb_q    = '{'{1, 1}, '{2, 2}};
    max_wait = 1;
    do_reset();
    intr = 1'b1;
    wait_halt("intr_ignored_halted");
    halt_hold("intr_ignored_hold", 10);
    intr = 1'b0;
    drained("intr_ignored");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
